ram_access_controller: RTL and testbench
========================================

# ram_access_controller

Sequencing front-end for the word-organised RAM array built from single-bit binary cells (one cell per bit, each with CLK, W, R, CS, D inputs and a gated OUT). It accepts one read or write request at a time over a valid/ready handshake and decodes the address to a one-hot row select. It drives the shared W/R/D lines to the array for exactly one cycle, captures the returned word on reads, and returns a response over a second valid/ready handshake. It sits directly upstream of the cell array.

## Interface
- WIDTH, 8, data word width (bits per row = cells per row)
- DEPTH, 16, number of rows; need not be a power of two
- AW, 4, address width; must satisfy 2^AW >= DEPTH

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_  in  1  reset, synchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  controller can accept a request
- REQ_WE  in  1  1 = write, 0 = read
- REQ_ADDR  in  AW  row address
- REQ_DIN  in  WIDTH  write data
- RSP_VALID  out  1  response present
- RSP_READY  in  1  consumer accepts the response
- RSP_RDATA  out  WIDTH  read data
- RSP_ERR  out  1  address was out of range
- ROW_CS  out  DEPTH  one-hot row select to the array
- CELL_W  out  1  write strobe, shared by all rows
- CELL_R  out  1  read strobe, shared by all rows
- CELL_D  out  WIDTH  write data bitlines
- CELL_Q  in  WIDTH  read bitlines from the selected row; valid only while CELL_R=1 and one ROW_CS bit is high

## Operation
- Three-state FSM: IDLE, ACCESS, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY, latch WE, ADDR and DIN, then go to ACCESS.
- ACCESS (exactly one cycle):
  - ROW_CS has bit ADDR set.
  - CELL_W=WE and CELL_R=~WE.
  - CELL_D=latched DIN.
  - The cell write commits at the rising edge that ends ACCESS.
  - On a read, CELL_Q is sampled into RSP_RDATA at that same edge.
  - Go to RESP.
- RESP:
  - RSP_VALID=1, RSP_RDATA and RSP_ERR held stable.
  - Stay in RESP until RSP_READY=1, then go to IDLE.
- Write response: RSP_RDATA=0, RSP_ERR=0.
- Out-of-range address (ADDR >= DEPTH):
  - The request is still accepted.
  - In ACCESS, ROW_CS=0, CELL_W=0 and CELL_R=0, so no cell is touched.
  - The response carries RSP_ERR=1 and RSP_RDATA=0, for both reads and writes.
- Invariants:
  - CELL_W and CELL_R are never both 1.
  - ROW_CS is all-zero outside ACCESS and has at most one bit set.
  - CELL_W, CELL_R and ROW_CS are 0 in IDLE and RESP.
- CELL_D holds its last value outside ACCESS; the array ignores it because CELL_W=0.
- All array-facing outputs come directly from flops, so there are no decode glitches on CS/W/R.
- Reset (RST_=0 sampled at an edge):
  - State goes to IDLE and RSP_VALID=0.
  - REQ_READY=0 while RST_=0.
  - ROW_CS=0, CELL_W=0, CELL_R=0, CELL_D=0, RSP_RDATA=0, RSP_ERR=0.
  - Array contents are not cleared.
- Reset during ACCESS:
  - The strobes were already high for that cycle, so a write commits at the reset edge.
  - Its response is discarded.
- Reset during RESP: the pending response is dropped.

## Timing
- Request accepted at edge E0; ACCESS is the cycle E0..E1; write commits and read data is captured at E1.
- RSP_VALID is high from E1 (after E1) onward.
- Minimum service time is 3 cycles per operation: accept, access, response with RSP_READY=1.
- REQ_READY returns high the cycle after the response handshake; there is no request/response overlap.
- Read latency from the request handshake edge to RSP_VALID rising: 1 cycle. RSP_RDATA is valid whenever RSP_VALID=1.
- Request inputs are don't-care except in the cycle where REQ_VALID&REQ_READY.
- RSP_READY is ignored outside RESP.
- RSP_READY=0 stalls the controller in RESP indefinitely, with outputs stable.

## Test plan
- Write 0xA5 to addr 3, then read addr 3:
  - ROW_CS=0x0008 and CELL_W=1 for exactly one cycle.
  - Read returns RSP_RDATA=0xA5, RSP_ERR=0, with RSP_VALID exactly 1 cycle after the request handshake edge.
- Write 0x3C to addr 0 and 0xFF to addr 15, then read addr 0 and addr 15:
  - Reads return 0x3C and 0xFF.
  - ROW_CS one-hot each access; CELL_W and CELL_R never both high.
- Backpressure:
  - Read with RSP_READY=0 for 5 cycles: RSP_VALID stays 1, RSP_RDATA stable, REQ_READY=0, strobes 0.
  - Raise RSP_READY: REQ_READY=1 on the next cycle.
- DEPTH=12, write to addr 13 then read addr 13:
  - Both responses give RSP_ERR=1 and RSP_RDATA=0.
  - ROW_CS stays 0 throughout.
  - A later read of addr 1 returns its previously written value.
- Reset mid-operation:
  - RST_=0 at the end of a write ACCESS: all outputs return to 0 and no response is issued.
  - A read after reset returns the new data, confirming the write committed.
  - RST_=0 during RESP: RSP_VALID=0 on the next cycle.

Source files
------------

// File: rtl/ram_access_controller.sv
// ram_access_controller: one-request-at-a-time sequencer in front of a word-organised
// RAM cell array; row select and W/R strobes are driven straight from flops.
//
// state  | meaning
// IDLE   | ready to accept a request
// ACCESS | row select and one strobe driven to the array for exactly one cycle
// RESP   | response presented and held until the consumer takes it
module ram_access_controller #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_din,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [DEPTH-1:0] row_cs,
    output logic             cell_w,
    output logic             cell_r,
    output logic [WIDTH-1:0] cell_d,
    input  logic [WIDTH-1:0] cell_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             in_range;
    logic             we_q;
    logic             err_q;
    logic [DEPTH-1:0] row_cs_nxt;
    logic             cell_w_nxt;
    logic             cell_r_nxt;
    logic [WIDTH-1:0] rdata_nxt;

    assign accept   = req_valid && req_ready;
    assign in_range = ({1'b0, req_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the flopped array strobes are decoded from the request itself,
    // so the strobes are high exactly during the cycle after acceptance.
    always_comb begin
        req_ready  = rst_ && (state == IDLE);
        rsp_valid  = (state == RESP);
        row_cs_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            row_cs_nxt[i] = accept && in_range && (req_addr == AW'(i));
        end
        cell_w_nxt = accept && in_range && req_we;
        cell_r_nxt = accept && in_range && !req_we;
        rdata_nxt  = (!we_q && !err_q) ? cell_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            row_cs    <= '0;
            cell_w    <= 1'b0;
            cell_r    <= 1'b0;
            cell_d    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            row_cs <= row_cs_nxt;
            cell_w <= cell_w_nxt;
            cell_r <= cell_r_nxt;
            if (accept) begin
                cell_d <= req_din;
                we_q   <= req_we;
                err_q  <= !in_range;
            end
            if (state == ACCESS) begin
                rsp_rdata <= rdata_nxt;
                rsp_err   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: two instances (16 and 12 rows) on shared stimulus,
// each backed by a bench cell array and checked every cycle against a transaction model.
module tb_ram_access_controller;

    localparam int DEPTH_OF [2] = '{16, 12};

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_      = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we    = 1'b0;
    logic [3:0] req_addr  = 4'd0;
    logic [7:0] req_din   = 8'd0;
    logic       rsp_ready = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a, cell_w_a, cell_r_a;
    logic [7:0]  rsp_rdata_a, cell_d_a, cell_q_a;
    logic [15:0] row_cs_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b, cell_w_b, cell_r_b;
    logic [7:0]  rsp_rdata_b, cell_d_b, cell_q_b;
    logic [11:0] row_cs_b;

    ram_access_controller #(.WIDTH(8), .DEPTH(16), .AW(4)) u_a (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .rsp_err(rsp_err_a), .row_cs(row_cs_a), .cell_w(cell_w_a), .cell_r(cell_r_a),
        .cell_d(cell_d_a), .cell_q(cell_q_a)
    );

    ram_access_controller #(.WIDTH(8), .DEPTH(12), .AW(4)) u_b (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b), .row_cs(row_cs_b), .cell_w(cell_w_b), .cell_r(cell_r_b),
        .cell_d(cell_d_b), .cell_q(cell_q_b)
    );

    logic [15:0] rcs [2];
    logic        cw [2], cr [2], rv [2], rr [2], re [2];
    logic [7:0]  cd [2], rd [2], cq [2];

    assign rcs[0] = row_cs_a;    assign rcs[1] = {4'b0, row_cs_b};
    assign cw[0]  = cell_w_a;    assign cw[1]  = cell_w_b;
    assign cr[0]  = cell_r_a;    assign cr[1]  = cell_r_b;
    assign rv[0]  = rsp_valid_a; assign rv[1]  = rsp_valid_b;
    assign rr[0]  = req_ready_a; assign rr[1]  = req_ready_b;
    assign re[0]  = rsp_err_a;   assign re[1]  = rsp_err_b;
    assign cd[0]  = cell_d_a;    assign cd[1]  = cell_d_b;
    assign rd[0]  = rsp_rdata_a; assign rd[1]  = rsp_rdata_b;
    assign cell_q_a = cq[0];
    assign cell_q_b = cq[1];

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en    = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [15:0] v);
        oh_idx = 0;
        for (int i = 0; i < 16; i++) if (v[i]) oh_idx = i;
    endfunction

    function automatic logic in_rng(input int k, input logic [3:0] a);
        return int'(a) < DEPTH_OF[k];
    endfunction

    // Bench cell arrays: a row is only readable/writable with exactly one select high;
    // anything else returns a junk pattern on the read bitlines.
    logic [7:0] arr [2][16] = '{default: '{default: 8'h00}};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (cw[k] && $onehot(rcs[k])) arr[k][oh_idx(rcs[k])] <= cd[k];
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cq[k] = 8'hE7;
            if (cr[k] && $onehot(rcs[k])) cq[k] = arr[k][oh_idx(rcs[k])];
        end
    end

    // Transaction model: phase 0 = waiting for a request, 1 = the one access cycle
    // after acceptance, 2 = response outstanding until rsp_ready.
    logic [7:0]  refm [2][16] = '{default: '{default: 8'h00}};
    int          phase [2]    = '{0, 0};
    logic [15:0] e_cs  [2]    = '{16'd0, 16'd0};
    logic        e_w   [2]    = '{1'b0, 1'b0};
    logic        e_r   [2]    = '{1'b0, 1'b0};
    logic        e_err [2]    = '{1'b0, 1'b0};
    logic        p_err [2]    = '{1'b0, 1'b0};
    logic [7:0]  e_d   [2]    = '{8'd0, 8'd0};
    logic [7:0]  e_rd  [2]    = '{8'd0, 8'd0};
    logic [7:0]  p_rd  [2]    = '{8'd0, 8'd0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_) begin
                phase[k] <= 0;
                e_cs[k]  <= 16'd0;
                e_w[k]   <= 1'b0;
                e_r[k]   <= 1'b0;
                e_d[k]   <= 8'd0;
                e_rd[k]  <= 8'd0;
                e_err[k] <= 1'b0;
            end else if (phase[k] == 0) begin
                if (req_valid) begin
                    phase[k] <= 1;
                    e_d[k]   <= req_din;
                    e_cs[k]  <= in_rng(k, req_addr) ? (16'd1 << req_addr) : 16'd0;
                    e_w[k]   <= in_rng(k, req_addr) && req_we;
                    e_r[k]   <= in_rng(k, req_addr) && !req_we;
                    p_err[k] <= !in_rng(k, req_addr);
                    p_rd[k]  <= (in_rng(k, req_addr) && !req_we) ? refm[k][req_addr] : 8'd0;
                    if (in_rng(k, req_addr) && req_we) refm[k][req_addr] <= req_din;
                end
            end else if (phase[k] == 1) begin
                phase[k] <= 2;
                e_cs[k]  <= 16'd0;
                e_w[k]   <= 1'b0;
                e_r[k]   <= 1'b0;
                e_rd[k]  <= p_rd[k];
                e_err[k] <= p_err[k];
            end else if (rsp_ready) begin
                phase[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("req_ready", k, 32'(rr[k]), 32'(rst_ && (phase[k] == 0)));
                chk("rsp_valid", k, 32'(rv[k]), 32'(phase[k] == 2));
                chk("row_cs",    k, 32'(rcs[k]), 32'(e_cs[k]));
                chk("cell_w",    k, 32'(cw[k]), 32'(e_w[k]));
                chk("cell_r",    k, 32'(cr[k]), 32'(e_r[k]));
                chk("w_and_r",   k, 32'(cw[k] && cr[k]), 32'd0);
                chk("cell_d",    k, 32'(cd[k]), 32'(e_d[k]));
                chk("rsp_rdata", k, 32'(rd[k]), 32'(e_rd[k]));
                chk("rsp_err",   k, 32'(re[k]), 32'(e_err[k]));
            end
        end
    end

    // Values captured by do_op for the hand-computed checks.
    logic [15:0] o_cs  [2];
    logic        o_w   [2];
    logic        o_w2  [2];
    logic        o_v   [2];
    logic [7:0]  o_rd  [2];
    logic        o_err [2];
    logic        o_rdy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_din   = 8'($urandom);
    endtask

    task automatic do_op(input logic we, input logic [3:0] addr, input logic [7:0] din, input int hold);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_din   = din;
        rsp_ready = 1'($urandom);
        step();
        for (int k = 0; k < 2; k++) begin
            o_cs[k] = rcs[k];
            o_w[k]  = cw[k];
        end
        junk();
        rsp_ready = 1'($urandom);
        step();
        for (int k = 0; k < 2; k++) begin
            o_w2[k]  = cw[k];
            o_v[k]   = rv[k];
            o_rd[k]  = rd[k];
            o_err[k] = re[k];
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            junk();
            step();
        end
        junk();
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'($urandom);
        o_rdy     = req_ready_a;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        chk("rst_req_ready", 0, 32'(req_ready_a), 32'd0);
        chk("rst_rsp_valid", 0, 32'(rsp_valid_a), 32'd0);
        rst_ = 1'b1;
        step();
        chk("post_rst_req_ready", 0, 32'(req_ready_a), 32'd1);

        for (int a = 0; a < 16; a++) do_op(1'b1, 4'(a), 8'($urandom), 0);

        do_op(1'b1, 4'd3, 8'hA5, 0);
        chk("wr3_row_cs", 0, 32'(o_cs[0]), 32'h0008);
        chk("wr3_row_cs", 1, 32'(o_cs[1]), 32'h0008);
        chk("wr3_cell_w", 0, 32'(o_w[0]), 32'd1);
        chk("wr3_cell_w_next", 0, 32'(o_w2[0]), 32'd0);
        do_op(1'b0, 4'd3, 8'h00, 0);
        chk("rd3_latency", 0, 32'(o_v[0]), 32'd1);
        chk("rd3_data", 0, 32'(o_rd[0]), 32'hA5);
        chk("rd3_err", 0, 32'(o_err[0]), 32'd0);
        chk("rd3_data", 1, 32'(o_rd[1]), 32'hA5);

        do_op(1'b1, 4'd0, 8'h3C, 0);
        do_op(1'b1, 4'd15, 8'hFF, 1);
        do_op(1'b0, 4'd0, 8'h00, 0);
        chk("rd0_data", 0, 32'(o_rd[0]), 32'h3C);
        do_op(1'b0, 4'd15, 8'h00, 2);
        chk("rd15_data", 0, 32'(o_rd[0]), 32'hFF);
        chk("rd15_err_d12", 1, 32'(o_err[1]), 32'd1);
        chk("rd15_data_d12", 1, 32'(o_rd[1]), 32'h00);

        do_op(1'b0, 4'd0, 8'h00, 5);
        chk("bp_data", 0, 32'(o_rd[0]), 32'h3C);
        chk("bp_ready_after", 0, 32'(o_rdy), 32'd1);

        do_op(1'b1, 4'd1, 8'h77, 0);
        do_op(1'b1, 4'd13, 8'h99, 0);
        chk("wr13_row_cs", 1, 32'(o_cs[1]), 32'd0);
        chk("wr13_err", 1, 32'(o_err[1]), 32'd1);
        chk("wr13_data", 1, 32'(o_rd[1]), 32'd0);
        do_op(1'b0, 4'd13, 8'h00, 0);
        chk("rd13_row_cs", 1, 32'(o_cs[1]), 32'd0);
        chk("rd13_err", 1, 32'(o_err[1]), 32'd1);
        chk("rd13_data", 1, 32'(o_rd[1]), 32'd0);
        chk("rd13_data", 0, 32'(o_rd[0]), 32'h99);
        do_op(1'b0, 4'd1, 8'h00, 0);
        chk("rd1_data", 1, 32'(o_rd[1]), 32'h77);

        // reset lands on the edge that ends a write access
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_din = 8'h5E;
        step();
        rst_ = 1'b0;
        step();
        chk("rst_acc_rsp_valid", 0, 32'(rsp_valid_a), 32'd0);
        chk("rst_acc_row_cs", 0, 32'(row_cs_a), 32'd0);
        chk("rst_acc_cell_d", 0, 32'(cell_d_a), 32'd0);
        req_valid = 1'b0;
        rst_ = 1'b1;
        step();
        chk("rst_acc_no_rsp", 0, 32'(rsp_valid_a), 32'd0);
        do_op(1'b0, 4'd5, 8'h00, 0);
        chk("rst_acc_committed", 0, 32'(o_rd[0]), 32'h5E);
        chk("rst_acc_committed", 1, 32'(o_rd[1]), 32'h5E);

        // reset while a response is pending
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chk("resp_pending", 0, 32'(rsp_valid_a), 32'd1);
        rst_ = 1'b0;
        step();
        chk("rst_resp_drop", 0, 32'(rsp_valid_a), 32'd0);
        rst_ = 1'b1;
        step();

        for (int n = 0; n < 150; n++)
            do_op(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
